// File: rtl/bicubic_write_bmp_pkg.sv
// rtl/bicubic_write_bmp_pkg.sv - BMP layout constants, header field offsets and sink FSM states
package bicubic_write_bmp_pkg;

    localparam int BMP_OFFSET    = 54;
    localparam int INFO_HDR_SIZE = 40;
    localparam int BPP           = 24;

    localparam logic [5:0] HOFF_FSIZE  = 6'd2;
    localparam logic [5:0] HOFF_OFFSET = 6'd10;
    localparam logic [5:0] HOFF_INFO   = 6'd14;
    localparam logic [5:0] HOFF_WIDTH  = 6'd18;
    localparam logic [5:0] HOFF_HEIGHT = 6'd22;
    localparam logic [5:0] HOFF_PLANES = 6'd26;
    localparam logic [5:0] HOFF_BPP    = 6'd28;
    localparam logic [5:0] HOFF_LAST   = 6'd53;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_RECV = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Little-endian byte sel (0..3) of a 32-bit header field.
    function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] sel);
        return v[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/bmp_hdr_rom.sv
// rtl/bmp_hdr_rom.sv - combinational 54-byte BMP header lookup, hdr_idx -> byte
module bmp_hdr_rom
    import bicubic_write_bmp_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int FSIZE      = 822,
    parameter int OFFSET     = BMP_OFFSET
) (
    input  logic [5:0] idx,
    output logic [7:0] hdr_byte
);

    function automatic logic in_u32(input logic [5:0] i, input logic [5:0] base);
        return (i >= base) && (i <= base + 6'd3);
    endfunction

    function automatic logic [1:0] rel(input logic [5:0] i, input logic [5:0] base);
        logic [5:0] d;
        d = i - base;
        return d[1:0];
    endfunction

    always_comb begin
        hdr_byte = 8'h00;
        if (idx == 6'd0) begin
            hdr_byte = 8'h42;
        end else if (idx == 6'd1) begin
            hdr_byte = 8'h4D;
        end else if (in_u32(idx, HOFF_FSIZE)) begin
            hdr_byte = le_byte(32'(FSIZE), rel(idx, HOFF_FSIZE));
        end else if (in_u32(idx, HOFF_OFFSET)) begin
            hdr_byte = le_byte(32'(OFFSET), rel(idx, HOFF_OFFSET));
        end else if (in_u32(idx, HOFF_INFO)) begin
            hdr_byte = le_byte(32'(INFO_HDR_SIZE), rel(idx, HOFF_INFO));
        end else if (in_u32(idx, HOFF_WIDTH)) begin
            hdr_byte = le_byte(32'(IMG_WIDTH), rel(idx, HOFF_WIDTH));
        end else if (in_u32(idx, HOFF_HEIGHT)) begin
            // Positive height marks the pixel array as bottom-up.
            hdr_byte = le_byte(32'(IMG_HEIGHT), rel(idx, HOFF_HEIGHT));
        end else if (idx == HOFF_PLANES) begin
            hdr_byte = 8'd1;
        end else if (idx == HOFF_BPP) begin
            hdr_byte = 8'(BPP);
        end
    end

endmodule

// File: rtl/bicubic_write_bmp.sv
// rtl/bicubic_write_bmp.sv - pixel stream sink building a 24bpp BMP in byte memory; optional BMP_WR_BACKPRESSURE_EN
module bicubic_write_bmp
    import bicubic_write_bmp_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int OFFSET     = BMP_OFFSET,
    parameter int ADDR_W     = $clog2(OFFSET + ((IMG_WIDTH * 3 + 3) / 4) * 4 * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [23:0]       data,
    output logic              ready,
    input  logic              restart,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              frame_done,
    output logic              done
);

    localparam int STRIDE   = ((IMG_WIDTH * 3 + 3) / 4) * 4;
    localparam int PAD      = STRIDE - IMG_WIDTH * 3;
    localparam int FSIZE    = OFFSET + STRIDE * IMG_HEIGHT;
    localparam int XW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PAD_LAST = (PAD > 0) ? PAD - 1 : 0;

    state_e            state_q, state_d;
    logic [5:0]        hdr_idx_q, hdr_idx_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [1:0]        pad_idx_q, pad_idx_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        rd_data_q, rd_data_d;

    logic [7:0]        mem [0:FSIZE-1];
    logic [7:0]        hdr_byte;
    logic              hdr_we, pix_we, pad_we, row_end, fire, gate;
    logic [ADDR_W-1:0] row_base, pix_addr, pad_addr;

`ifdef BMP_WR_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11, free-running from reset.
    always_comb lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end

    assign gate = lfsr_q[0];
`else
    assign gate = 1'b1;
`endif

    assign ready      = (state_q == ST_RECV) & gate;
    assign fire       = valid & ready;
    assign done       = (state_q == ST_DONE);
    assign frame_done = frame_done_q;
    assign rd_data    = rd_data_q;

    bmp_hdr_rom #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .FSIZE     (FSIZE),
        .OFFSET    (OFFSET)
    ) u_hdr_rom (
        .idx     (hdr_idx_q),
        .hdr_byte(hdr_byte)
    );

    // Rows are stored bottom-up: top raster row lands at the highest row slot.
    always_comb begin
        row_base = ADDR_W'(OFFSET) + (ADDR_W'(IMG_HEIGHT - 1) - ADDR_W'(y_q)) * ADDR_W'(STRIDE);
        pix_addr = row_base + ADDR_W'(x_q) * ADDR_W'(3);
        pad_addr = row_base + ADDR_W'(IMG_WIDTH * 3) + ADDR_W'(pad_idx_q);
    end

    always_comb begin
        state_d      = state_q;
        hdr_idx_d    = hdr_idx_q;
        x_d          = x_q;
        y_d          = y_q;
        pad_idx_d    = pad_idx_q;
        frame_done_d = 1'b0;
        hdr_we       = 1'b0;
        pix_we       = 1'b0;
        pad_we       = 1'b0;
        row_end      = 1'b0;

        case (state_q)
            ST_HDR: begin
                hdr_we = 1'b1;
                if (hdr_idx_q == HOFF_LAST) state_d = ST_RECV;
                else                        hdr_idx_d = hdr_idx_q + 6'd1;
            end
            ST_RECV: begin
                if (fire) begin
                    pix_we = 1'b1;
                    if (x_q == XW'(IMG_WIDTH - 1)) begin
                        x_d = '0;
                        if (PAD > 0) begin
                            state_d   = ST_PAD;
                            pad_idx_d = '0;
                        end else begin
                            row_end = 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_PAD: begin
                pad_we    = 1'b1;
                pad_idx_d = pad_idx_q + 2'd1;
                if (pad_idx_q == 2'(PAD_LAST)) row_end = 1'b1;
            end
            ST_DONE: begin
                if (restart) begin
                    state_d   = ST_HDR;
                    hdr_idx_d = '0;
                    x_d       = '0;
                    y_d       = '0;
                end
            end
            default: state_d = ST_HDR;
        endcase

        // y stays at the last row in DONE; restart clears it.
        if (row_end) begin
            if (y_q == YW'(IMG_HEIGHT - 1)) begin
                state_d      = ST_DONE;
                frame_done_d = 1'b1;
            end else begin
                y_d     = y_q + 1'b1;
                state_d = ST_RECV;
            end
        end

        rd_data_d = (32'(rd_addr) < FSIZE) ? mem[rd_addr] : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HDR;
            hdr_idx_q    <= '0;
            x_q          <= '0;
            y_q          <= '0;
            pad_idx_q    <= '0;
            frame_done_q <= 1'b0;
            rd_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pad_idx_q    <= pad_idx_d;
            frame_done_q <= frame_done_d;
            rd_data_q    <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hdr_we) mem[ADDR_W'(hdr_idx_q)] <= hdr_byte;
        if (pad_we) mem[pad_addr] <= 8'h00;
        if (pix_we) begin
            mem[pix_addr]              <= data[7:0];
            mem[pix_addr + ADDR_W'(1)] <= data[15:8];
            mem[pix_addr + ADDR_W'(2)] <= data[23:16];
        end
    end

endmodule

// File: tb/tb_bicubic_write_bmp.sv
// tb/tb_bicubic_write_bmp.sv - self-checking bench for bicubic_write_bmp at 3x2 (padded rows)
module tb_bicubic_write_bmp;

    localparam int W      = 3;
    localparam int H      = 2;
    localparam int STRIDE = 12;
    localparam int FSIZE  = 78;
    localparam int AW     = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [23:0]   data = '0;
    logic          restart = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          ready, frame_done, done;
    logic [7:0]    rd_data;

    int total = 0;
    int bad = 0;
    int fd_count = 0;

    logic [7:0]  gold [FSIZE];
    logic [23:0] pix  [W*H];

    typedef struct {
        int         addr;
        logic [7:0] exp;
    } spot_t;
    spot_t spots[$];

    always #5 clk = ~clk;

    bicubic_write_bmp #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .data      (data),
        .ready     (ready),
        .restart   (restart),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .frame_done(frame_done),
        .done      (done)
    );

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put32(input int a, input int v);
        for (int i = 0; i < 4; i++) gold[a+i] = 8'((v >> (8 * i)) & 255);
    endtask

    task automatic build_gold();
        int a;
        for (int i = 0; i < FSIZE; i++) gold[i] = 8'h00;
        gold[0] = 8'h42;
        gold[1] = 8'h4D;
        put32(2, FSIZE);
        put32(10, 54);
        put32(14, 40);
        put32(18, W);
        put32(22, H);
        gold[26] = 8'd1;
        gold[28] = 8'd24;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                a = 54 + (H - 1 - r) * STRIDE + 3 * c;
                gold[a]   = pix[r*W+c][7:0];
                gold[a+1] = pix[r*W+c][15:8];
                gold[a+2] = pix[r*W+c][23:16];
            end
        end
    endtask

    task automatic new_pixels();
        for (int k = 0; k < W * H; k++) pix[k] = 24'($urandom);
    endtask

    task automatic push(input logic [23:0] d);
        int n;
        n = 0;
        valid = 1'b1;
        data  = d;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL push_timeout: ready stayed %b, required 1", ready);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic measure_hdr(input string name, input int exp);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, n, exp);
    endtask

    task automatic send_frame(input int gap_at);
        int n;
        for (int k = 0; k < W * H; k++) begin
            push(pix[k]);
            if (k == gap_at) repeat (5) @(negedge clk);
            if ((k % W) == W - 1 && k != W * H - 1) begin
                n = 0;
                while (ready !== 1'b1 && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                check($sformatf("pad_stall_row%0d", k / W), n, 3);
            end
        end
        n = 0;
        while (frame_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_latency", n, 3);
        check("done_level", done, 1);
        check("ready_in_done", ready, 0);
        @(negedge clk);
        check("frame_done_width", frame_done, 0);
    endtask

    task automatic dump_check(input string name);
        for (int a = 0; a < FSIZE; a++) begin
            rd_addr = AW'(a);
            @(negedge clk);
            check($sformatf("%s_mem%0d", name, a), rd_data, gold[a]);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_done", done, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_rd_data", rd_data, 0);

        rst_n = 1'b1;
        @(negedge clk);
        measure_hdr("reset_hdr_cycles", 53);

        // Frame 1: known first pixel, byte-order and padding spot checks
        new_pixels();
        pix[0] = 24'h112233;
        build_gold();
        send_frame(-1);
        dump_check("f1");

        spots.push_back('{0, 8'h42});
        spots.push_back('{1, 8'h4D});
        spots.push_back('{2, 8'h4E});
        spots.push_back('{3, 8'h00});
        spots.push_back('{10, 8'd54});
        spots.push_back('{14, 8'd40});
        spots.push_back('{18, 8'd3});
        spots.push_back('{22, 8'd2});
        spots.push_back('{26, 8'd1});
        spots.push_back('{28, 8'd24});
        spots.push_back('{63, 8'h00});
        spots.push_back('{64, 8'h00});
        spots.push_back('{65, 8'h00});
        spots.push_back('{66, 8'h33});
        spots.push_back('{67, 8'h22});
        spots.push_back('{68, 8'h11});
        spots.push_back('{75, 8'h00});
        spots.push_back('{76, 8'h00});
        spots.push_back('{77, 8'h00});
        for (int i = 0; i < spots.size(); i++) begin
            rd_addr = AW'(spots[i].addr);
            @(negedge clk);
            check($sformatf("spot_mem%0d", spots[i].addr), rd_data, spots[i].exp);
        end

        // DONE ignores input
        valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data = 24'($urandom);
            @(negedge clk);
            check($sformatf("done_ready_c%0d", i), ready, 0);
            check($sformatf("done_hold_c%0d", i), done, 1);
        end
        valid = 1'b0;
        dump_check("f1_after_done");

        // Restart, second frame with a mid-row source gap
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_done_low", done, 0);
        measure_hdr("restart_hdr_cycles", 54);
        new_pixels();
        build_gold();
        send_frame(1);
        dump_check("f2");
        check("frame_count_f2", fd_count, 2);

        // Reset in the middle of the second row
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        measure_hdr("restart2_hdr_cycles", 54);
        new_pixels();
        for (int k = 0; k < W + 1; k++) push(pix[k]);
        valid = 1'b1;
        data  = pix[W+1];
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ready, 0);
        check("midrst_done", done, 0);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        measure_hdr("midrst_hdr_cycles", 53);
        new_pixels();
        build_gold();
        send_frame(-1);
        dump_check("f4");
        check("frame_count_end", fd_count, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
